// File: rtl/ma_pkg.sv
// ma_pkg: shared types and constants for the memory-access dispatcher.
//   ma_disp_state_e : dispatcher FSM states
//   ma_cmd_t        : one queued load/store command
//   CH_*            : channel slots in the internal channel vectors
//                     (VRF load, VRF store, then one slot per MRF bank)
package ma_pkg;

    localparam int MA_ROW_BYTES     = 128;
    localparam int MA_VRF_ADDRWIDTH = 10;
    localparam int MA_ARF_ADDRWIDTH = 5;
    localparam int MA_ARF_DATAWIDTH = 36;

    localparam int CH_VRF_LD   = 0;
    localparam int CH_VRF_ST   = 1;
    localparam int CH_MRF_BASE = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARF_WAIT  = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_DONE      = 3'd4
    } ma_disp_state_e;

    typedef struct packed {
        logic                        select_v_m;
        logic                        load_or_store;
        logic [MA_VRF_ADDRWIDTH-1:0] v_m_reg;
        logic [MA_ARF_ADDRWIDTH-1:0] a_reg;
        logic [MA_ARF_DATAWIDTH-1:0] a_offset;
    } ma_cmd_t;

endpackage

// File: rtl/ma_cmd_fifo.sv
// ma_cmd_fifo: synchronous FIFO of ma_cmd_t commands.
//   clk, rst_n  : clock, async active-low reset (empties the queue)
//   push, wdata : write request / command; ignored while full
//   pop, rdata  : read request / head command (show-ahead); ignored while empty
//   full, empty : occupancy flags, derived from registered pointers only
module ma_cmd_fifo
    import ma_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  ma_cmd_t wdata,
    input  logic    pop,
    output ma_cmd_t rdata,
    output logic    full,
    output logic    empty
);
    localparam int PW = $clog2(DEPTH);

    ma_cmd_t        mem_r [DEPTH];
    logic [PW:0]    wptr_r;
    logic [PW:0]    rptr_r;
    logic           do_push_s;
    logic           do_pop_s;

    // Extra pointer MSB distinguishes full from empty when indices match.
    assign full      = (wptr_r[PW] != rptr_r[PW]) && (wptr_r[PW-1:0] == rptr_r[PW-1:0]);
    assign empty     = (wptr_r == rptr_r);
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign rdata     = mem_r[rptr_r[PW-1:0]];

    // Pointer and storage update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r <= '0;
            rptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (do_push_s) begin
                mem_r[wptr_r[PW-1:0]] <= wdata;
                wptr_r                <= wptr_r + 1'b1;
            end
            if (do_pop_s) begin
                rptr_r <= rptr_r + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ma_dispatch.sv
// ma_dispatch: memory-access front end. Queues load/store commands, resolves
// the base address through the ARF, fans the command out to the MRF bank
// channels (matrix) or one VRF channel (vector) and pulses ma_done_o once
// every issued channel has been accepted and has reported done.
//   ma_ddr4_calib_complete_i / ma_ddr4_linkup_o : calibration gate
//   cmd_*                   : command offer from the decoder
//   ma_done_o / ma_busy_o   : completion pulse / activity flag
//   arf_*                   : ARF read port (1-cycle latency)
//   mrf_*                   : per-bank datamover channels
//   vrf_*                   : VRF load/store datamover channels
module ma_dispatch
    import ma_pkg::*;
#(
    parameter int NUM_OF_DDR4      = 4,
    parameter int NUM_MRF_BANKS    = 4,
    parameter int DDR4_ADDRWIDTH   = 36,
    parameter int ARF_ADDRWIDTH    = MA_ARF_ADDRWIDTH,
    parameter int ARF_DATAWIDTH    = DDR4_ADDRWIDTH,
    parameter int VRF_ADDRWIDTH    = MA_VRF_ADDRWIDTH,
    parameter int MRF_ADDRWIDTH    = 6,
    parameter int BYTE_TRANS_WIDTH = 15,
    parameter int ROW_BYTES        = MA_ROW_BYTES,
    parameter int CMD_FIFO_DEPTH   = 4
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [NUM_OF_DDR4-1:0]                  ma_ddr4_calib_complete_i,
    output logic                                    ma_ddr4_linkup_o,
    input  logic                                    cmd_valid_i,
    output logic                                    cmd_ready_o,
    input  logic                                    cmd_select_v_m_i,
    input  logic                                    cmd_v_load_or_store_i,
    input  logic [VRF_ADDRWIDTH-1:0]                cmd_v_m_reg_i,
    input  logic [ARF_ADDRWIDTH-1:0]                cmd_a_reg_i,
    input  logic [ARF_DATAWIDTH-1:0]                cmd_a_offset_i,
    output logic                                    ma_done_o,
    output logic                                    ma_busy_o,
    output logic                                    arf_en_o,
    output logic                                    arf_we_o,
    output logic [ARF_ADDRWIDTH-1:0]                arf_addr_o,
    input  logic [ARF_DATAWIDTH-1:0]                arf_dout_i,
    output logic [NUM_MRF_BANKS-1:0]                mrf_cmd_valid_o,
    input  logic [NUM_MRF_BANKS-1:0]                mrf_cmd_ready_i,
    output logic [NUM_MRF_BANKS*DDR4_ADDRWIDTH-1:0] mrf_cmd_addr_o,
    output logic [BYTE_TRANS_WIDTH-1:0]             mrf_cmd_btt_o,
    input  logic [NUM_MRF_BANKS-1:0]                mrf_done_i,
    output logic                                    vrf_ld_cmd_valid_o,
    output logic                                    vrf_st_cmd_valid_o,
    input  logic                                    vrf_ld_cmd_ready_i,
    input  logic                                    vrf_st_cmd_ready_i,
    output logic [DDR4_ADDRWIDTH-1:0]               vrf_cmd_addr_o,
    output logic [VRF_ADDRWIDTH-1:0]                vrf_cmd_bram_addr_o,
    output logic [BYTE_TRANS_WIDTH-1:0]             vrf_cmd_btt_o,
    input  logic                                    vrf_ld_done_i,
    input  logic                                    vrf_st_done_i
);
    localparam int NCH        = NUM_MRF_BANKS + CH_MRF_BASE;
    localparam int BANK_BYTES = ROW_BYTES * (2 ** MRF_ADDRWIDTH);
    localparam logic [DDR4_ADDRWIDTH-1:0]   BANK_STRIDE = DDR4_ADDRWIDTH'(BANK_BYTES);
    localparam logic [BYTE_TRANS_WIDTH-1:0] MRF_BTT     = BYTE_TRANS_WIDTH'(BANK_BYTES);
    localparam logic [BYTE_TRANS_WIDTH-1:0] VRF_BTT     = BYTE_TRANS_WIDTH'(ROW_BYTES);

    ma_disp_state_e                              state_r, state_next_s;
    logic                                        linkup_r;
    logic                                        sel_r, ls_r;
    logic [VRF_ADDRWIDTH-1:0]                    vreg_r;
    logic [ARF_DATAWIDTH-1:0]                    offset_r;
    logic [NCH-1:0]                              pending_r, valid_r, accepted_r, done_r;
    logic [NCH-1:0]                              ready_s, done_in_s, accept_s;
    logic [NCH-1:0]                              accepted_next_s, done_next_s, mask_s;
    logic [NUM_MRF_BANKS-1:0][DDR4_ADDRWIDTH-1:0] mrf_addr_r, bank_addr_s;
    logic [DDR4_ADDRWIDTH-1:0]                   base_s, vrf_addr_r;
    logic [VRF_ADDRWIDTH-1:0]                    vrf_bram_r;
    logic [BYTE_TRANS_WIDTH-1:0]                 mrf_btt_r, vrf_btt_r;
    logic                                        ma_done_r;
    logic                                        pop_s, fifo_full_s, fifo_empty_s;
    ma_cmd_t                                     cmd_in_s, head_s;

    assign cmd_in_s = '{select_v_m:    cmd_select_v_m_i,
                        load_or_store: cmd_v_load_or_store_i,
                        v_m_reg:       cmd_v_m_reg_i,
                        a_reg:         cmd_a_reg_i,
                        a_offset:      cmd_a_offset_i};

    ma_cmd_fifo #(.DEPTH(CMD_FIFO_DEPTH)) u_cmd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid_i),
        .wdata (cmd_in_s),
        .pop   (pop_s),
        .rdata (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Channel vectors: slot 0 VRF load, slot 1 VRF store, slots 2.. MRF banks.
    assign ready_s   = {mrf_cmd_ready_i, vrf_st_cmd_ready_i, vrf_ld_cmd_ready_i};
    assign done_in_s = {mrf_done_i, vrf_st_done_i, vrf_ld_done_i};

    assign cmd_ready_o         = !fifo_full_s;
    assign ma_busy_o           = !fifo_empty_s || (state_r != ST_IDLE);
    assign ma_ddr4_linkup_o    = linkup_r;
    assign ma_done_o           = ma_done_r;
    assign arf_en_o            = pop_s;
    assign arf_we_o            = 1'b0;
    assign arf_addr_o          = pop_s ? head_s.a_reg : '0;
    assign mrf_cmd_valid_o     = valid_r[NCH-1:CH_MRF_BASE];
    assign mrf_cmd_addr_o      = mrf_addr_r;
    assign mrf_cmd_btt_o       = mrf_btt_r;
    assign vrf_ld_cmd_valid_o  = valid_r[CH_VRF_LD];
    assign vrf_st_cmd_valid_o  = valid_r[CH_VRF_ST];
    assign vrf_cmd_addr_o      = vrf_addr_r;
    assign vrf_cmd_bram_addr_o = vrf_bram_r;
    assign vrf_cmd_btt_o       = vrf_btt_r;

    // Base address, channel mask and per-bank addresses for the command in flight.
    always_comb begin
        base_s = arf_dout_i + offset_r;
        mask_s = '0;
        if (sel_r) begin
            mask_s[NCH-1:CH_MRF_BASE] = '1;
        end else if (ls_r) begin
            mask_s[CH_VRF_ST] = 1'b1;
        end else begin
            mask_s[CH_VRF_LD] = 1'b1;
        end
        for (int b = 0; b < NUM_MRF_BANKS; b++) begin
            bank_addr_s[b] = base_s + DDR4_ADDRWIDTH'(b) * BANK_STRIDE;
        end
    end

    // Handshake bookkeeping and FSM next state. A done pulse only counts for a
    // pending channel accepted earlier or in this very cycle.
    always_comb begin
        pop_s           = 1'b0;
        state_next_s    = state_r;
        accept_s        = valid_r & ready_s;
        accepted_next_s = accepted_r | accept_s;
        done_next_s     = done_r | (done_in_s & pending_r & accepted_next_s);
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s && linkup_r) begin
                    pop_s        = 1'b1;
                    state_next_s = ST_ARF_WAIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ARF_WAIT: state_next_s = ST_ISSUE;
            ST_ISSUE: begin
                if (done_next_s == pending_r) begin
                    state_next_s = ST_DONE;
                end else if (accepted_next_s == pending_r) begin
                    state_next_s = ST_WAIT_DONE;
                end else begin
                    state_next_s = ST_ISSUE;
                end
            end
            ST_WAIT_DONE: begin
                if (done_next_s == pending_r) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_WAIT_DONE;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM state, linkup register and completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            linkup_r  <= 1'b0;
            ma_done_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            linkup_r  <= &ma_ddr4_calib_complete_i;
            ma_done_r <= (state_next_s == ST_DONE);
        end
    end

    // Command capture, channel tracking and datamover command registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_r      <= 1'b0;
            ls_r       <= 1'b0;
            vreg_r     <= '0;
            offset_r   <= '0;
            pending_r  <= '0;
            valid_r    <= '0;
            accepted_r <= '0;
            done_r     <= '0;
            mrf_addr_r <= '0;
            mrf_btt_r  <= '0;
            vrf_addr_r <= '0;
            vrf_bram_r <= '0;
            vrf_btt_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        sel_r    <= head_s.select_v_m;
                        ls_r     <= head_s.load_or_store;
                        vreg_r   <= head_s.v_m_reg;
                        offset_r <= head_s.a_offset;
                    end
                end
                ST_ARF_WAIT: begin
                    pending_r  <= mask_s;
                    valid_r    <= mask_s;
                    accepted_r <= '0;
                    done_r     <= '0;
                    if (sel_r) begin
                        mrf_addr_r <= bank_addr_s;
                        mrf_btt_r  <= MRF_BTT;
                    end else begin
                        vrf_addr_r <= base_s;
                        vrf_bram_r <= vreg_r;
                        vrf_btt_r  <= VRF_BTT;
                    end
                end
                ST_ISSUE: begin
                    valid_r    <= valid_r & ~accept_s;
                    accepted_r <= accepted_next_s;
                    done_r     <= done_next_s;
                end
                ST_WAIT_DONE: begin
                    done_r <= done_next_s;
                end
                default: begin
                    valid_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ma_dispatch.sv
// tb_ma_dispatch: directed self-checking bench for ma_dispatch with a small
// behavioural ARF (1-cycle read latency) and hand-driven datamover channels.
module tb_ma_dispatch;

    localparam int NB = 4;
    localparam int AW = 36;

    logic             clk;
    logic             rst_n;
    logic [3:0]       calib;
    logic             linkup;
    logic             cmd_valid, cmd_ready, cmd_sel, cmd_ls;
    logic [9:0]       cmd_vreg;
    logic [4:0]       cmd_areg;
    logic [AW-1:0]    cmd_off;
    logic             ma_done, ma_busy;
    logic             arf_en, arf_we;
    logic [4:0]       arf_addr;
    logic [AW-1:0]    arf_dout;
    logic [NB-1:0]    mrf_valid, mrf_ready, mrf_done;
    logic [NB*AW-1:0] mrf_addr;
    logic [14:0]      mrf_btt;
    logic             ld_valid, st_valid, ld_ready, st_ready, ld_done, st_done;
    logic [AW-1:0]    vrf_addr;
    logic [9:0]       vrf_bram;
    logic [14:0]      vrf_btt;
    logic [AW-1:0]    arf_mem [32];

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    ma_dispatch dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .ma_ddr4_calib_complete_i (calib),
        .ma_ddr4_linkup_o         (linkup),
        .cmd_valid_i              (cmd_valid),
        .cmd_ready_o              (cmd_ready),
        .cmd_select_v_m_i         (cmd_sel),
        .cmd_v_load_or_store_i    (cmd_ls),
        .cmd_v_m_reg_i            (cmd_vreg),
        .cmd_a_reg_i              (cmd_areg),
        .cmd_a_offset_i           (cmd_off),
        .ma_done_o                (ma_done),
        .ma_busy_o                (ma_busy),
        .arf_en_o                 (arf_en),
        .arf_we_o                 (arf_we),
        .arf_addr_o               (arf_addr),
        .arf_dout_i               (arf_dout),
        .mrf_cmd_valid_o          (mrf_valid),
        .mrf_cmd_ready_i          (mrf_ready),
        .mrf_cmd_addr_o           (mrf_addr),
        .mrf_cmd_btt_o            (mrf_btt),
        .mrf_done_i               (mrf_done),
        .vrf_ld_cmd_valid_o       (ld_valid),
        .vrf_st_cmd_valid_o       (st_valid),
        .vrf_ld_cmd_ready_i       (ld_ready),
        .vrf_st_cmd_ready_i       (st_ready),
        .vrf_cmd_addr_o           (vrf_addr),
        .vrf_cmd_bram_addr_o      (vrf_bram),
        .vrf_cmd_btt_o            (vrf_btt),
        .vrf_ld_done_i            (ld_done),
        .vrf_st_done_i            (st_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ARF model: registered read, one cycle of latency.
    always @(posedge clk) begin
        if (arf_en) arf_dout <= arf_mem[arf_addr];
    end

    task automatic chk(input string tag, input bit ok);
        n_total++;
        if (ok) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic sel, input logic ls, input logic [9:0] vreg,
                           input logic [4:0] areg, input logic [AW-1:0] off);
        cmd_valid = 1'b1;
        cmd_sel   = sel;
        cmd_ls    = ls;
        cmd_vreg  = vreg;
        cmd_areg  = areg;
        cmd_off   = off;
    endtask

    initial begin
        rst_n = 1'b0; calib = 4'b0111; cmd_valid = 1'b0; cmd_sel = 1'b0; cmd_ls = 1'b0;
        cmd_vreg = '0; cmd_areg = '0; cmd_off = '0; arf_dout = '0;
        mrf_ready = '0; mrf_done = '0; ld_ready = 1'b0; st_ready = 1'b0;
        ld_done = 1'b0; st_done = 1'b0;
        for (int i = 0; i < 32; i++) arf_mem[i] = '0;
        arf_mem[1] = 36'h100;
        arf_mem[2] = 36'h5000;
        arf_mem[3] = 36'h1000;
        arf_mem[4] = 36'hF_FFFF_FFC0;

        tick(); tick();
        chk("rst_valids", {mrf_valid, ld_valid, st_valid} === 6'b0);
        chk("rst_done", ma_done === 1'b0);
        chk("rst_linkup", linkup === 1'b0);
        chk("rst_arf_en", arf_en === 1'b0);
        chk("rst_ready_busy", {cmd_ready, ma_busy, arf_we} === 3'b100);
        chk("rst_addrs", {mrf_addr, vrf_addr, vrf_bram, mrf_btt, vrf_btt} === '0);
        rst_n = 1'b1;

        set_cmd(1'b0, 1'b0, 10'd5, 5'd3, 36'h80);
        tick();
        cmd_valid = 1'b0;
        tick(); tick();
        chk("gate_no_arf", {linkup, arf_en, ma_busy} === 3'b001);
        calib = 4'b1111;
        chk("gate_linkup_lag", linkup === 1'b0);
        tick();
        chk("gate_pop", {linkup, arf_en, arf_addr} === {2'b11, 5'd3});
        tick();
        chk("arf_en_one_cycle", arf_en === 1'b0);
        tick();
        chk("ld_valids", {mrf_valid, ld_valid, st_valid} === 6'b0000_10);
        chk("ld_cmd", {vrf_addr, vrf_bram, vrf_btt} === {36'h1080, 10'd5, 15'd128});
        ld_ready = 1'b1;
        tick();
        ld_ready = 1'b0;
        chk("ld_retired", ld_valid === 1'b0);
        tick();
        chk("ld_no_early_done", ma_done === 1'b0);
        ld_done = 1'b1;
        tick();
        ld_done = 1'b0;
        chk("ld_done_pulse", ma_done === 1'b1);
        tick();
        chk("ld_done_once", {ma_done, ma_busy} === 2'b00);

        set_cmd(1'b1, 1'b0, 10'd0, 5'd0, 36'h0);
        tick();
        cmd_valid = 1'b0;
        tick(); tick();
        chk("mx_valid_all", {mrf_valid, ld_valid, st_valid} === 6'b1111_00);
        chk("mx_addrs", mrf_addr === {36'h6000, 36'h4000, 36'h2000, 36'h0});
        chk("mx_btt", mrf_btt === 15'd8192);
        mrf_ready = 4'b1001;
        tick();
        chk("mx_c1", mrf_valid === 4'b0110);
        mrf_ready = 4'b0010; mrf_done = 4'b1000;
        tick();
        chk("mx_c2", mrf_valid === 4'b0100);
        chk("mx_addr_stable", mrf_addr === {36'h6000, 36'h4000, 36'h2000, 36'h0});
        mrf_ready = 4'b0000; mrf_done = 4'b0001;
        tick();
        mrf_ready = 4'b0100; mrf_done = 4'b0000;
        tick();
        chk("mx_c4_all_accepted", {mrf_valid, ma_done} === 5'b0);
        mrf_ready = 4'b0000; mrf_done = 4'b0100;
        tick();
        chk("mx_c5_not_done", ma_done === 1'b0);
        mrf_done = 4'b0010;
        tick();
        mrf_done = 4'b0000;
        chk("mx_done", ma_done === 1'b1);
        tick();
        chk("mx_done_once", ma_done === 1'b0);

        set_cmd(1'b1, 1'b0, 10'd0, 5'd1, 36'h20);
        tick();
        cmd_valid = 1'b0;
        tick(); tick();
        chk("sc_addrs", mrf_addr === {36'h6120, 36'h4120, 36'h2120, 36'h120});
        mrf_ready = 4'b0001; mrf_done = 4'b0011; st_done = 1'b1;
        tick();
        st_done = 1'b0; mrf_done = 4'b0000; mrf_ready = 4'b1110;
        chk("sc_d1", mrf_valid === 4'b1110);
        tick();
        mrf_ready = 4'b0000; mrf_done = 4'b1100;
        tick();
        mrf_done = 4'b0000;
        chk("sc_early_done_ignored", ma_done === 1'b0);
        mrf_done = 4'b0010;
        tick();
        mrf_done = 4'b0000;
        chk("sc_done", ma_done === 1'b1);
        tick();

        set_cmd(1'b0, 1'b1, 10'd0, 5'd2, 36'h0);
        tick();
        cmd_valid = 1'b0;
        tick(); tick();
        chk("qf_s0", {st_valid, ld_valid, vrf_addr} === {2'b10, 36'h5000});
        for (int k = 1; k <= 4; k++) begin
            set_cmd(1'b0, 1'b1, 10'(k), 5'd2, 36'(k * 256));
            tick();
        end
        chk("qf_full", cmd_ready === 1'b0);
        set_cmd(1'b0, 1'b1, 10'd5, 5'd2, 36'h500);
        tick();
        chk("qf_still_full", cmd_ready === 1'b0);
        st_ready = 1'b1;
        tick();
        st_ready = 1'b0; st_done = 1'b1;
        tick();
        st_done = 1'b0;
        chk("qf_s0_done", ma_done === 1'b1);
        tick();
        chk("qf_pop_cycle", {arf_en, cmd_ready} === 2'b10);
        tick();
        cmd_valid = 1'b0;
        chk("qf_after_pop", cmd_ready === 1'b1);
        for (int k = 1; k <= 4; k++) begin
            for (int w = 0; w < 20 && !st_valid; w++) tick();
            chk("qf_drain_valid", st_valid === 1'b1);
            chk("qf_drain_cmd", {vrf_addr, vrf_bram} === {36'h5000 + 36'(k * 256), 10'(k)});
            st_ready = 1'b1;
            tick();
            st_ready = 1'b0; st_done = 1'b1;
            tick();
            st_done = 1'b0;
            chk("qf_drain_done", ma_done === 1'b1);
            tick();
        end
        for (int w = 0; w < 10; w++) tick();
        chk("qf_no_sixth", {ma_busy, st_valid} === 2'b00);

        set_cmd(1'b0, 1'b0, 10'd7, 5'd4, 36'h80);
        tick();
        set_cmd(1'b0, 1'b0, 10'd1, 5'd0, 36'h0);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("wrap_cmd", {ld_valid, vrf_addr, vrf_bram} === {1'b1, 36'h40, 10'd7});
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valids", {mrf_valid, ld_valid, st_valid, ma_done} === 7'b0);
        chk("rst_mid_queue", {ma_busy, cmd_ready} === 2'b01);
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk("rst_queue_cleared", {linkup, arf_en, ma_busy} === 3'b100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
